// File: rtl/ahb_lite_arbiter_2to1.sv
// Two-master, one-slave AHB-Lite arbiter for shared block memory.
// Losing masters are stalled via HREADYOUT and their address phase is replayed.
module ahb_lite_arbiter_2to1 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL0,
    input  logic [31:0] HADDR0,
    input  logic [1:0]  HTRANS0,
    input  logic [2:0]  HSIZE0,
    input  logic [3:0]  HPROT0,
    input  logic        HWRITE0,
    input  logic [31:0] HWDATA0,
    input  logic        HREADY0,
    output logic        HREADYOUT0,
    output logic [31:0] HRDATA0,
    output logic        HRESP0,
    input  logic        HSEL1,
    input  logic [31:0] HADDR1,
    input  logic [1:0]  HTRANS1,
    input  logic [2:0]  HSIZE1,
    input  logic [3:0]  HPROT1,
    input  logic        HWRITE1,
    input  logic [31:0] HWDATA1,
    input  logic        HREADY1,
    output logic        HREADYOUT1,
    output logic [31:0] HRDATA1,
    output logic        HRESP1,
    output logic        HSEL_S,
    output logic [31:0] HADDR_S,
    output logic [1:0]  HTRANS_S,
    output logic [2:0]  HSIZE_S,
    output logic [3:0]  HPROT_S,
    output logic        HWRITE_S,
    output logic [31:0] HWDATA_S,
    output logic        HREADY_S,
    input  logic        HREADYOUT_S,
    input  logic [31:0] HRDATA_S,
    input  logic        HRESP_S
);

    logic        live0, live1;
    logic        req0, req1;
    logic        gnt, gnt_m;
    logic        gnt0, gnt1;
    logic        pend0_q, pend1_q;
    logic        pend0_d, pend1_d;
    logic        cap0, cap1;
    logic [31:0] addr0_q, addr1_q;
    logic [2:0]  size0_q, size1_q;
    logic [3:0]  prot0_q, prot1_q;
    logic        wr0_q, wr1_q;
    logic        last_q;
    logic        dv_q;
    logic        own_q;
    logic        sel_q;
    logic        unused_ok;

    assign live0 = HSEL0 & HTRANS0[1] & HREADY0;
    assign live1 = HSEL1 & HTRANS1[1] & HREADY1;
    assign req0  = live0 | pend0_q;
    assign req1  = live1 | pend1_q;
    assign gnt   = HREADYOUT_S & (req0 | req1);

    // gnt_m selects master 1; ties go to the master not granted last
    always_comb begin
        gnt_m = ~req0;
        if (req0 & req1) begin
            gnt_m = ROUND_ROBIN ? ~last_q : 1'b0;
        end
    end

    assign gnt0 = gnt & ~gnt_m;
    assign gnt1 = gnt & gnt_m;

    assign cap0    = live0 & ~gnt0;
    assign cap1    = live1 & ~gnt1;
    assign pend0_d = ~gnt0 & (live0 | pend0_q);
    assign pend1_d = ~gnt1 & (live1 | pend1_q);

    always_comb begin
        HADDR_S  = HADDR0;
        HSIZE_S  = HSIZE0;
        HPROT_S  = HPROT0;
        HWRITE_S = HWRITE0;
        unique case (1'b1)
            gnt0 & pend0_q: begin
                HADDR_S  = addr0_q;
                HSIZE_S  = size0_q;
                HPROT_S  = prot0_q;
                HWRITE_S = wr0_q;
            end
            gnt1 & pend1_q: begin
                HADDR_S  = addr1_q;
                HSIZE_S  = size1_q;
                HPROT_S  = prot1_q;
                HWRITE_S = wr1_q;
            end
            gnt1 & ~pend1_q: begin
                HADDR_S  = HADDR1;
                HSIZE_S  = HSIZE1;
                HPROT_S  = HPROT1;
                HWRITE_S = HWRITE1;
            end
            default: ;
        endcase
    end

    // during slave wait states the previous address phase is held
    assign HSEL_S   = HREADYOUT_S ? gnt : sel_q;
    assign HTRANS_S = HSEL_S ? 2'b10 : 2'b00;
    assign HREADY_S = HREADYOUT_S;
    assign HWDATA_S = own_q ? HWDATA1 : HWDATA0;

    assign HREADYOUT0 = (dv_q & ~own_q) ? HREADYOUT_S : ~pend0_q;
    assign HREADYOUT1 = (dv_q &  own_q) ? HREADYOUT_S : ~pend1_q;
    assign HRESP0     = dv_q & ~own_q & HRESP_S;
    assign HRESP1     = dv_q &  own_q & HRESP_S;
    assign HRDATA0    = HRDATA_S;
    assign HRDATA1    = HRDATA_S;

    assign unused_ok = &{1'b0, HTRANS0[0], HTRANS1[0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            addr0_q <= '0;
            addr1_q <= '0;
            size0_q <= '0;
            size1_q <= '0;
            prot0_q <= '0;
            prot1_q <= '0;
            wr0_q   <= 1'b0;
            wr1_q   <= 1'b0;
            last_q  <= 1'b1;
            dv_q    <= 1'b0;
            own_q   <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            sel_q   <= HSEL_S;
            if (cap0) begin
                addr0_q <= HADDR0;
                size0_q <= HSIZE0;
                prot0_q <= HPROT0;
                wr0_q   <= HWRITE0;
            end
            if (cap1) begin
                addr1_q <= HADDR1;
                size1_q <= HSIZE1;
                prot1_q <= HPROT1;
                wr1_q   <= HWRITE1;
            end
            if (gnt) begin
                last_q <= gnt_m;
            end
            if (HREADYOUT_S) begin
                dv_q  <= gnt;
                own_q <= gnt_m;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_arbiter_2to1.sv
// Bench for ahb_lite_arbiter_2to1: round-robin and fixed-priority instances
// checked each cycle against a transaction-level reference model.
module tb_ahb_lite_arbiter_2to1;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;
    logic HRESETn;

    logic        hsel   [2][2];
    logic [31:0] haddr  [2][2];
    logic [1:0]  htrans [2][2];
    logic [2:0]  hsize  [2][2];
    logic [3:0]  hprot  [2][2];
    logic        hwrite [2][2];
    logic [31:0] hwdata [2][2];
    logic        hro    [2][2];
    logic [31:0] hrd    [2][2];
    logic        hrsp   [2][2];

    logic        sel_s   [2];
    logic [31:0] addr_s  [2];
    logic [1:0]  trans_s [2];
    logic [2:0]  size_s  [2];
    logic [3:0]  prot_s  [2];
    logic        wr_s    [2];
    logic [31:0] wd_s    [2];
    logic        rdy_s   [2];

    logic        sready;
    logic [31:0] srd;
    logic        srsp;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahb_lite_arbiter_2to1 #(.ROUND_ROBIN(g == 0)) u_dut (
            .HCLK(HCLK), .HRESETn(HRESETn),
            .HSEL0(hsel[g][0]), .HADDR0(haddr[g][0]),
            .HTRANS0(htrans[g][0]), .HSIZE0(hsize[g][0]),
            .HPROT0(hprot[g][0]), .HWRITE0(hwrite[g][0]),
            .HWDATA0(hwdata[g][0]), .HREADY0(hro[g][0]),
            .HREADYOUT0(hro[g][0]), .HRDATA0(hrd[g][0]),
            .HRESP0(hrsp[g][0]),
            .HSEL1(hsel[g][1]), .HADDR1(haddr[g][1]),
            .HTRANS1(htrans[g][1]), .HSIZE1(hsize[g][1]),
            .HPROT1(hprot[g][1]), .HWRITE1(hwrite[g][1]),
            .HWDATA1(hwdata[g][1]), .HREADY1(hro[g][1]),
            .HREADYOUT1(hro[g][1]), .HRDATA1(hrd[g][1]),
            .HRESP1(hrsp[g][1]),
            .HSEL_S(sel_s[g]), .HADDR_S(addr_s[g]),
            .HTRANS_S(trans_s[g]), .HSIZE_S(size_s[g]),
            .HPROT_S(prot_s[g]), .HWRITE_S(wr_s[g]),
            .HWDATA_S(wd_s[g]), .HREADY_S(rdy_s[g]),
            .HREADYOUT_S(sready), .HRDATA_S(srd), .HRESP_S(srsp)
        );
    end

    // reference model state, per instance g and master m
    bit          pend  [2][2];
    logic [31:0] baddr [2][2];
    logic [2:0]  bsize [2][2];
    logic [3:0]  bprot [2][2];
    bit          bwr   [2][2];
    int          last  [2];
    bit          dv    [2];
    int          own   [2];
    bit          selh  [2];
    bit          took  [2][2];
    int          cnt   [2][2];

    int nvec;
    int nbad;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            for (int m = 0; m < 2; m++) pend[g][m] = 0;
            last[g] = 1;
            dv[g]   = 0;
            own[g]  = 0;
            selh[g] = 0;
        end
    endtask

    task automatic model_step();
        for (int g = 0; g < 2; g++) begin
            bit          lv [2];
            bit          rq [2];
            bit          gnt;
            int          win;
            bit          esel;
            logic [31:0] ea;
            logic [2:0]  es;
            logic [3:0]  ep;
            logic        ew;
            for (int m = 0; m < 2; m++) begin
                lv[m] = hsel[g][m] && htrans[g][m][1] && hro[g][m];
                rq[m] = lv[m] || pend[g][m];
            end
            gnt = sready && (rq[0] || rq[1]);
            if (rq[0] && rq[1]) win = (g == 0) ? 1 - last[g] : 0;
            else win = rq[0] ? 0 : 1;
            esel = sready ? gnt : selh[g];
            ea = haddr[g][0]; es = hsize[g][0];
            ep = hprot[g][0]; ew = hwrite[g][0];
            if (gnt && pend[g][win]) begin
                ea = baddr[g][win]; es = bsize[g][win];
                ep = bprot[g][win]; ew = bwr[g][win];
            end else if (gnt) begin
                ea = haddr[g][win]; es = hsize[g][win];
                ep = hprot[g][win]; ew = hwrite[g][win];
            end
            check($sformatf("i%0d.hsel_s", g), sel_s[g], esel);
            check($sformatf("i%0d.htrans_s", g), trans_s[g], esel ? 2 : 0);
            check($sformatf("i%0d.haddr_s", g), addr_s[g], ea);
            check($sformatf("i%0d.hsize_s", g), size_s[g], es);
            check($sformatf("i%0d.hprot_s", g), prot_s[g], ep);
            check($sformatf("i%0d.hwrite_s", g), wr_s[g], ew);
            check($sformatf("i%0d.hready_s", g), rdy_s[g], sready);
            if (dv[g])
                check($sformatf("i%0d.hwdata_s", g), wd_s[g], hwdata[g][own[g]]);
            for (int m = 0; m < 2; m++) begin
                bit isown;
                isown = dv[g] && own[g] == m;
                check($sformatf("i%0d.hreadyout%0d", g, m), hro[g][m],
                      isown ? sready : !pend[g][m]);
                check($sformatf("i%0d.hresp%0d", g, m), hrsp[g][m],
                      isown ? srsp : 1'b0);
                check($sformatf("i%0d.hrdata%0d", g, m), hrd[g][m], srd);
            end
            if (HRESETn) begin
                for (int m = 0; m < 2; m++) begin
                    if (gnt && win == m) begin
                        pend[g][m] = 0;
                    end else if (lv[m]) begin
                        pend[g][m]  = 1;
                        baddr[g][m] = haddr[g][m];
                        bsize[g][m] = hsize[g][m];
                        bprot[g][m] = hprot[g][m];
                        bwr[g][m]   = hwrite[g][m];
                    end
                end
                if (gnt) last[g] = win;
                if (sready) begin
                    dv[g] = gnt;
                    if (gnt) own[g] = win;
                end
                selh[g] = esel;
            end
        end
    endtask

    task automatic half();
        @(negedge HCLK);
        model_step();
        for (int g = 0; g < 2; g++)
            for (int m = 0; m < 2; m++) took[g][m] = hro[g][m];
    endtask

    task automatic adv();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_m(int m, bit s, logic [1:0] t, logic [31:0] a,
                         bit w, logic [31:0] wd);
        for (int g = 0; g < 2; g++) begin
            hsel[g][m]   = s;
            htrans[g][m] = t;
            haddr[g][m]  = a;
            hwrite[g][m] = w;
            hwdata[g][m] = wd;
            hsize[g][m]  = 3'd2;
            hprot[g][m]  = 4'h3;
        end
    endtask

    task automatic issue(int g, int m, int n);
        hsel[g][m]   = 1'b1;
        htrans[g][m] = 2'b10;
        haddr[g][m]  = ((m + 1) << 12) | (n * 4);
        hwrite[g][m] = 1'b0;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        model_reset();
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        sready = 1'b1;
        srsp   = 1'b0;
        half();
        adv();
        HRESETn = 1'b1;
    endtask

    initial begin
        nvec = 0;
        nbad = 0;
        srd  = '0;
        do_reset();
        HRESETn = 1'b0;
        for (int g = 0; g < 2; g++) begin
            check("rst_hsel_s", sel_s[g], 0);
            check("rst_htrans_s", trans_s[g], 0);
            check("rst_hreadyout0", hro[g][0], 1);
            check("rst_hreadyout1", hro[g][1], 1);
            check("rst_hresp1", hrsp[g][1], 0);
        end
        HRESETn = 1'b1;

        // M0 alone reads 0x100
        set_m(0, 1, 2'b10, 32'h100, 0, 0);
        half();
        for (int g = 0; g < 2; g++) begin
            check("t1_hsel_s", sel_s[g], 1);
            check("t1_haddr_s", addr_s[g], 32'h100);
        end
        adv();
        set_m(0, 0, 0, 0, 0, 0);
        srd = 32'hDEADBEEF;
        half();
        for (int g = 0; g < 2; g++) begin
            check("t1_hrdata0", hrd[g][0], 32'hDEADBEEF);
            check("t1_hreadyout0", hro[g][0], 1);
        end
        adv();

        // simultaneous requests, M1 write is replayed
        do_reset();
        set_m(0, 1, 2'b10, 32'h10, 0, 0);
        set_m(1, 1, 2'b10, 32'h20, 1, 0);
        half();
        for (int g = 0; g < 2; g++) begin
            check("t2_first_addr", addr_s[g], 32'h10);
            check("t2_m1_rdy_a", hro[g][1], 1);
        end
        adv();
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 32'h12345678);
        half();
        for (int g = 0; g < 2; g++) begin
            check("t2_m1_stall", hro[g][1], 0);
            check("t2_replay_addr", addr_s[g], 32'h20);
            check("t2_replay_wr", wr_s[g], 1);
        end
        adv();
        half();
        for (int g = 0; g < 2; g++) begin
            check("t2_hwdata_s", wd_s[g], 32'h12345678);
            check("t2_m1_rdy_c", hro[g][1], 1);
        end
        adv();

        // continuous issue: alternation vs fixed priority
        do_reset();
        for (int g = 0; g < 2; g++)
            for (int m = 0; m < 2; m++) begin
                cnt[g][m] = 0;
                issue(g, m, 0);
            end
        for (int k = 0; k < 8; k++) begin
            half();
            check("rr_alt", addr_s[0][13:12], (k % 2 == 0) ? 1 : 2);
            check("fp_m0", addr_s[1][13:12], 1);
            adv();
            for (int g = 0; g < 2; g++)
                for (int m = 0; m < 2; m++)
                    if (took[g][m]) begin
                        cnt[g][m]++;
                        issue(g, m, cnt[g][m]);
                    end
        end
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        repeat (2) begin half(); adv(); end

        // two slave wait states while M1 requests
        do_reset();
        set_m(0, 1, 2'b10, 32'h300, 0, 0);
        half(); adv();
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 1, 2'b10, 32'h400, 0, 0);
        sready = 1'b0;
        half();
        for (int g = 0; g < 2; g++) begin
            check("t4_w1_rdy0", hro[g][0], 0);
            check("t4_w1_htrans", trans_s[g], 2);
        end
        adv();
        set_m(1, 0, 0, 0, 0, 0);
        half();
        for (int g = 0; g < 2; g++) begin
            check("t4_w2_rdy0", hro[g][0], 0);
            check("t4_w2_htrans", trans_s[g], 2);
            check("t4_w2_rdy1", hro[g][1], 0);
        end
        adv();
        sready = 1'b1;
        half();
        for (int g = 0; g < 2; g++) begin
            check("t4_rdy0", hro[g][0], 1);
            check("t4_m1_grant", addr_s[g], 32'h400);
        end
        adv();
        half(); adv();

        // two-cycle ERROR to M1
        do_reset();
        set_m(1, 1, 2'b10, 32'h40, 0, 0);
        half(); adv();
        set_m(1, 0, 0, 0, 0, 0);
        sready = 1'b0;
        srsp   = 1'b1;
        half();
        for (int g = 0; g < 2; g++) begin
            check("t5_e1_resp1", hrsp[g][1], 1);
            check("t5_e1_rdy1", hro[g][1], 0);
            check("t5_e1_resp0", hrsp[g][0], 0);
        end
        adv();
        sready = 1'b1;
        half();
        for (int g = 0; g < 2; g++) begin
            check("t5_e2_resp1", hrsp[g][1], 1);
            check("t5_e2_rdy1", hro[g][1], 1);
            check("t5_e2_resp0", hrsp[g][0], 0);
        end
        adv();
        srsp = 1'b0;

        // reset while M1 is pending
        do_reset();
        set_m(0, 1, 2'b10, 32'h50, 0, 0);
        set_m(1, 1, 2'b10, 32'h60, 0, 0);
        half(); adv();
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        half();
        for (int g = 0; g < 2; g++) check("t6_pend1", hro[g][1], 0);
        #2;
        HRESETn = 1'b0;
        model_reset();
        #1;
        for (int g = 0; g < 2; g++) begin
            check("t6_rst_rdy1", hro[g][1], 1);
            check("t6_rst_resp0", hrsp[g][0], 0);
        end
        adv();
        HRESETn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            half();
            for (int g = 0; g < 2; g++) check("t6_no_replay", sel_s[g], 0);
            adv();
        end

        // randomized traffic
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            sready = ($urandom % 4) != 0;
            srsp   = ($urandom % 8) == 0;
            srd    = $urandom;
            for (int g = 0; g < 2; g++)
                for (int m = 0; m < 2; m++)
                    if (took[g][m]) begin
                        hsel[g][m]   = ($urandom % 4) != 0;
                        htrans[g][m] = 2'($urandom % 4);
                        haddr[g][m]  = $urandom;
                        hsize[g][m]  = 3'($urandom % 8);
                        hprot[g][m]  = 4'($urandom % 16);
                        hwrite[g][m] = 1'($urandom % 2);
                        hwdata[g][m] = $urandom;
                    end
            half();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
